// File: rtl/irrigation_pkg.sv
// ============================================================================
// irrigation_pkg : shared tank-level encoding and debounce counter width
// Rev 1.0
// ============================================================================
`default_nettype none

package irrigation_pkg;

    localparam int C_DEB_CNT_W = 4;

    typedef enum logic [1:0] {
        LVL_EMPTY   = 2'd0,
        LVL_PARTIAL = 2'd1,
        LVL_FULL    = 2'd2,
        LVL_FAULT   = 2'd3
    } level_state_t;

endpackage : irrigation_pkg

`default_nettype wire

// File: rtl/debounce_filter.sv
// ============================================================================
// debounce_filter : two-flop synchronizer plus tick-qualified debounce counter
// Rev 1.0
// ============================================================================
`default_nettype none

module debounce_filter
    import irrigation_pkg::*;
#(
    parameter int unsigned DEBOUNCE_N = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic stable
);

    localparam logic [C_DEB_CNT_W-1:0] C_THRESH  = C_DEB_CNT_W'(DEBOUNCE_N);
    localparam logic [C_DEB_CNT_W-1:0] C_CNT_MAX = '1;

    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_stable;
    logic [C_DEB_CNT_W-1:0] r_cnt;
    logic [C_DEB_CNT_W-1:0] w_cnt_inc;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    end

    // Stable value flips on the tick that brings the count up to the threshold.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (tick) begin
            if (r_sync2 != r_stable) begin
                if (w_cnt_inc >= C_THRESH) begin
                    r_stable <= ~r_stable;
                    r_cnt    <= '0;
                end else begin
                    r_cnt    <= w_cnt_inc;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign stable = r_stable;

endmodule : debounce_filter

`default_nettype wire

// File: rtl/tank_sensor_conditioner.sv
// ============================================================================
// tank_sensor_conditioner : debounced tank/soil sensors, level FSM, fill hysteresis
// Rev 1.0
// ============================================================================
`default_nettype none

module tank_sensor_conditioner
    import irrigation_pkg::*;
#(
    parameter int unsigned DEBOUNCE_N = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       lower_sw_raw,
    input  logic       upper_sw_raw,
    input  logic       soil_dry_raw,
    output logic       lower_level,
    output logic       upper_level,
    output logic       soil_dry,
    output logic [1:0] level_state,
    output logic       fill_request,
    output logic       level_error
);

    logic         w_lower;
    logic         w_upper;
    logic         w_soil;
    level_state_t r_state;
    level_state_t w_next;
    logic         r_fill;

    debounce_filter #(.DEBOUNCE_N(DEBOUNCE_N)) u_deb_lower (
        .clock (clock), .reset (reset), .tick (tick), .raw (lower_sw_raw), .stable (w_lower)
    );
    debounce_filter #(.DEBOUNCE_N(DEBOUNCE_N)) u_deb_upper (
        .clock (clock), .reset (reset), .tick (tick), .raw (upper_sw_raw), .stable (w_upper)
    );
    debounce_filter #(.DEBOUNCE_N(DEBOUNCE_N)) u_deb_soil (
        .clock (clock), .reset (reset), .tick (tick), .raw (soil_dry_raw), .stable (w_soil)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= LVL_EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    // Both switches are decoded together, so simultaneous changes never pass through an intermediate state.
    always_comb begin
        w_next = r_state;
        if (r_state == LVL_FAULT) begin
            if (!w_lower && !w_upper) begin
                w_next = LVL_EMPTY;
            end
        end else begin
            unique case ({w_lower, w_upper})
                2'b00:   w_next = LVL_EMPTY;
                2'b10:   w_next = LVL_PARTIAL;
                2'b11:   w_next = LVL_FULL;
                2'b01:   w_next = LVL_FAULT;
                default: w_next = r_state;
            endcase
        end
    end

    // Fill hysteresis: open at EMPTY, close at FULL or FAULT, PARTIAL leaves it alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fill <= 1'b1;
        end else if (w_next == LVL_EMPTY) begin
            r_fill <= 1'b1;
        end else if ((w_next == LVL_FULL) || (w_next == LVL_FAULT)) begin
            r_fill <= 1'b0;
        end
    end

    always_comb begin
        lower_level  = w_lower;
        upper_level  = w_upper;
        soil_dry     = w_soil;
        level_state  = r_state;
        fill_request = r_fill;
        level_error  = (r_state == LVL_FAULT);
    end

endmodule : tank_sensor_conditioner

`default_nettype wire

// File: tb/tb_tank_sensor_conditioner.sv
// ============================================================================
// tb_tank_sensor_conditioner : vector table with expectation queue plus timing sequences
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tank_sensor_conditioner;

    localparam int N = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick;
    logic       lower_sw_raw;
    logic       upper_sw_raw;
    logic       soil_dry_raw;
    logic       lower_level;
    logic       upper_level;
    logic       soil_dry;
    logic [1:0] level_state;
    logic       fill_request;
    logic       level_error;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    tank_sensor_conditioner #(.DEBOUNCE_N(N)) dut (
        .clock        (clock),
        .reset        (reset),
        .tick         (tick),
        .lower_sw_raw (lower_sw_raw),
        .upper_sw_raw (upper_sw_raw),
        .soil_dry_raw (soil_dry_raw),
        .lower_level  (lower_level),
        .upper_level  (upper_level),
        .soil_dry     (soil_dry),
        .level_state  (level_state),
        .fill_request (fill_request),
        .level_error  (level_error)
    );

    typedef struct {
        logic       lo;
        logic       up;
        logic       soil;
        logic       e_lo;
        logic       e_up;
        logic       e_soil;
        logic [1:0] e_st;
        logic       e_fill;
        logic       e_err;
    } vec_t;

    vec_t vecs[14];
    vec_t exp_q[$];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic t);
        tick = t;
        @(posedge clock);
        #1;
        tick = 1'b0;
    endtask

    task automatic tick_period();
        cyc(1'b1);
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b0);
    endtask

    task automatic do_reset();
        lower_sw_raw = 1'b0;
        upper_sw_raw = 1'b0;
        soil_dry_raw = 1'b0;
        reset = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        reset = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".lower_level"},  {3'b0, lower_level},  4'd0);
        check({tag, ".upper_level"},  {3'b0, upper_level},  4'd0);
        check({tag, ".soil_dry"},     {3'b0, soil_dry},     4'd0);
        check({tag, ".level_state"},  {2'b0, level_state},  4'd0);
        check({tag, ".fill_request"}, {3'b0, fill_request}, 4'd1);
        check({tag, ".level_error"},  {3'b0, level_error},  4'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // {lo, up, soil, exp lower, exp upper, exp soil, exp state, exp fill, exp err}
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0};

        tick = 1'b0;
        do_reset();
        check_reset_vals("reset");

        // Latency: raw edge, two sync cycles, then N ticks; state lags one cycle.
        lower_sw_raw = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        for (int k = 1; k <= N; k++) begin
            cyc(1'b1);
            check($sformatf("latency.lower_after_tick%0d", k), {3'b0, lower_level}, (k == N) ? 4'd1 : 4'd0);
            if (k == N) begin
                check("latency.state_same_cycle", {2'b0, level_state}, 4'd0);
                cyc(1'b0);
                check("latency.state_next_cycle", {2'b0, level_state}, 4'd1);
                check("latency.fill_kept", {3'b0, fill_request}, 4'd1);
            end else begin
                cyc(1'b0);
                cyc(1'b0);
                cyc(1'b0);
            end
        end

        // Glitch of N-1 ticks is rejected, then a full N-tick hold is accepted.
        do_reset();
        soil_dry_raw = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        for (int k = 0; k < N - 1; k++) tick_period();
        check("glitch.during", {3'b0, soil_dry}, 4'd0);
        soil_dry_raw = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        for (int k = 0; k < N + 1; k++) tick_period();
        check("glitch.after", {3'b0, soil_dry}, 4'd0);
        soil_dry_raw = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        for (int k = 1; k <= N; k++) begin
            tick_period();
            check($sformatf("glitch.hold_tick%0d", k), {3'b0, soil_dry}, (k == N) ? 4'd1 : 4'd0);
        end

        // Reset mid-debounce, coincident with a tick, discards the partial count.
        do_reset();
        lower_sw_raw = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        tick_period();
        tick_period();
        reset = 1'b1;
        cyc(1'b1);
        reset = 1'b0;
        check_reset_vals("midreset");
        cyc(1'b0);
        cyc(1'b0);
        for (int k = 1; k <= N; k++) begin
            tick_period();
            check($sformatf("midreset.lower_tick%0d", k), {3'b0, lower_level}, (k == N) ? 4'd1 : 4'd0);
        end

        // Table walk through the level FSM and fill hysteresis.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            vec_t e;
            lower_sw_raw = vecs[i].lo;
            upper_sw_raw = vecs[i].up;
            soil_dry_raw = vecs[i].soil;
            exp_q.push_back(vecs[i]);
            cyc(1'b0);
            cyc(1'b0);
            for (int k = 0; k < N + 1; k++) tick_period();
            cyc(1'b0);
            check($sformatf("vec%0d.queue_nonempty", i), {3'b0, (exp_q.size() != 0)}, 4'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check($sformatf("vec%0d.lower_level", i),  {3'b0, lower_level},  {3'b0, e.e_lo});
                check($sformatf("vec%0d.upper_level", i),  {3'b0, upper_level},  {3'b0, e.e_up});
                check($sformatf("vec%0d.soil_dry", i),     {3'b0, soil_dry},     {3'b0, e.e_soil});
                check($sformatf("vec%0d.level_state", i),  {2'b0, level_state},  {2'b0, e.e_st});
                check($sformatf("vec%0d.fill_request", i), {3'b0, fill_request}, {3'b0, e.e_fill});
                check($sformatf("vec%0d.level_error", i),  {3'b0, level_error},  {3'b0, e.e_err});
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_tank_sensor_conditioner

`default_nettype wire
